// File: rtl/multiplier.sv
// Iterative 32x32 -> 64-bit shift-add multiplier (MULT/MULTU) with a start/busy handshake.
// Works on operand magnitudes and applies the product sign once, on the final step.
module multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   s
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 sign_q, sign_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 busy_q, busy_d;
    logic [2*WIDTH-1:0]   s_q, s_d;

    logic [WIDTH:0]       step_sum;
    logic [2*WIDTH-1:0]   step_acc;

    // -2^31 negates to 0x8000_0000, which is the correct magnitude read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        logic [WIDTH-1:0] r;
        if (neg) begin
            r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Next-state: the low half of acc holds the remaining multiplier bits, the upper half the partial sum.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        sign_d   = sign_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        busy_d   = busy_q;
        s_d      = s_q;

        if (acc_q[0]) begin
            step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        end else begin
            step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        end
        step_acc = {step_sum, acc_q[WIDTH-1:1]};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    count_d = {CNT_W{1'b0}};
                    sign_d  = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    mcand_d = magnitude(a, is_signed & a[WIDTH-1]);
                    acc_d   = {{WIDTH{1'b0}}, magnitude(b, is_signed & b[WIDTH-1])};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d   = step_acc;
                count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (count_q == CNT_W'(WIDTH-1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    if (sign_q) begin
                        s_d = ~step_acc + {{(2*WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        s_d = step_acc;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; rst aborts any operation and clears the product.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= {CNT_W{1'b0}};
            sign_q  <= 1'b0;
            mcand_q <= {WIDTH{1'b0}};
            acc_q   <= {(2*WIDTH){1'b0}};
            busy_q  <= 1'b0;
            s_q     <= {(2*WIDTH){1'b0}};
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sign_q  <= sign_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            s_q     <= s_d;
        end
    end

    assign busy = busy_q;
    assign s    = s_q;

endmodule

// File: tb/tb_multiplier.sv
// Directed self-checking bench for the iterative multiplier: products, latency and handshake.
module tb_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [63:0] s;

    int          n_cmp;
    int          n_bad;
    logic [63:0] last_s;
    longint      model;

    multiplier #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .s         (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One operation: busy over E0..E31, s frozen mid-op, result at E32.
    // poke: cycle at which a stray start with other operands is pulsed (0 = none).
    // late: hold start across E32, which must not launch a new operation.
    task automatic run_op(input string tag, input logic sg, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp,
                          input int poke, input bit late);
        @(negedge clk);
        start = 1'b1; is_signed = sg; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; is_signed = ~sg;
        check({tag, " busy@E0"}, {63'd0, busy}, 64'd1);
        for (int i = 1; i <= 31; i++) begin
            if (i == poke) begin
                @(negedge clk);
                start = 1'b1; a = 32'd3; b = 32'd5;
                @(posedge clk); #1;
                start = 1'b0;
            end else if (late && i == 31) begin
                @(negedge clk);
                start = 1'b1; a = 32'd7; b = 32'd9;
                @(posedge clk); #1;
            end else begin
                @(posedge clk); #1;
            end
        end
        check({tag, " busy@E31"}, {63'd0, busy}, 64'd1);
        check({tag, " s held mid-op"}, s, last_s);
        @(negedge clk);
        @(posedge clk); #1;
        check({tag, " busy@E32"}, {63'd0, busy}, 64'd0);
        check({tag, " product"}, s, exp);
        last_s = exp;
        if (late) begin
            @(negedge clk);
            start = 1'b0;
            @(posedge clk); #1;
            check({tag, " start@E32 ignored"}, {63'd0, busy}, 64'd0);
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; last_s = 64'd0;
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = 32'd0; b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset s", s, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("s 87359729*23422", 1'b1, 32'd87359729, 32'd23422, 64'd2046139572638, 0, 1'b0);
        run_op("s -77*999", 1'b1, 32'hFFFF_FFB3, 32'd999, 64'hFFFF_FFFF_FFFE_D385, 0, 1'b0);
        model = 64'sd809843053 * -64'sd328932;
        run_op("s 809843053*-328932", 1'b1, 32'd809843053, 32'hFFFA_FB1C, 64'(model), 0, 1'b0);
        run_op("s min*min", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 1'b0);
        run_op("u F398F1AB*FFFFFFFF", 1'b0, 32'hF398_F1AB, 32'hFFFF_FFFF, 64'hF398_F1AA_0C67_0E55, 0, 1'b0);
        model = 64'd33329255 * 64'd45825983;
        run_op("u 33329255*45825983", 1'b0, 32'd33329255, 32'd45825983, 64'(model), 0, 1'b0);
        run_op("s 0*-5", 1'b1, 32'd0, 32'hFFFF_FFFB, 64'd0, 0, 1'b0);
        run_op("start while busy", 1'b1, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, 7, 1'b0);
        run_op("start at E32", 1'b0, 32'd1000, 32'd1000, 64'd1000000, 0, 1'b1);

        repeat (20) @(posedge clk);
        #1;
        check("s held idle", s, last_s);
        check("idle busy", {63'd0, busy}, 64'd0);

        // Abort mid-operation with rst.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = 32'd12345; b = 32'd678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst mid-op busy", {63'd0, busy}, 64'd0);
        check("rst mid-op s", s, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        last_s = 64'd0;
        run_op("after rst u 6*7", 1'b0, 32'd6, 32'd7, 64'd42, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
